// File: rtl/cpu_bus_arbiter.sv
// Round-robin arbiter merging NCH CPU memory masters onto one memory bus.
// Fixed memory read latency LAT; all outputs registered.
//
// Ports:
//   iCLK, iRST         clock, synchronous active-low reset
//   iReq/iWe/iBE       per-channel request, write flag, byte enables (packed)
//   iAddr/iWData       per-channel address and write data (packed, ch0 in LSBs)
//   oGnt               one-hot grant during the strobe cycle
//   oValid             one-hot completion pulse
//   oRData             captured read data, held between reads
//   oMemRE/oMemWE      memory read / write strobes
//   oMemBE/oMemAddr    memory byte enables and address
//   oMemWData          memory write data
//   iMemRData          memory read data
module cpu_bus_arbiter #(
    parameter int NCH    = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LAT    = 1
) (
    input  logic                       iCLK,
    input  logic                       iRST,
    input  logic [NCH-1:0]             iReq,
    input  logic [NCH-1:0]             iWe,
    input  logic [NCH*(DATA_W/8)-1:0]  iBE,
    input  logic [NCH*ADDR_W-1:0]      iAddr,
    input  logic [NCH*DATA_W-1:0]      iWData,
    output logic [NCH-1:0]             oGnt,
    output logic [NCH-1:0]             oValid,
    output logic [DATA_W-1:0]          oRData,
    output logic                       oMemRE,
    output logic                       oMemWE,
    output logic [DATA_W/8-1:0]        oMemBE,
    output logic [ADDR_W-1:0]          oMemAddr,
    output logic [DATA_W-1:0]          oMemWData,
    input  logic [DATA_W-1:0]          iMemRData
);

    localparam int BW = DATA_W / 8;
    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {
        sIdle,
        sStrobe,
        sWait,
        sResp
    } stateT;

    stateT             state;
    stateT             nxtState;
    logic [CW-1:0]     rrPtr;
    logic [CW-1:0]     nxtRrPtr;
    logic [CW-1:0]     curCh;
    logic [CW-1:0]     nxtCh;
    logic              curWe;
    logic              nxtWe;
    logic [2:0]        cnt;
    logic [2:0]        nxtCnt;

    logic [NCH-1:0]    nxtGnt;
    logic [NCH-1:0]    nxtValid;
    logic [DATA_W-1:0] nxtRData;
    logic              nxtMemRE;
    logic              nxtMemWE;
    logic [BW-1:0]     nxtMemBE;
    logic [ADDR_W-1:0] nxtMemAddr;
    logic [DATA_W-1:0] nxtMemWData;

    // Round-robin pick: first requester at or after rrPtr.
    // The wrap uses a compare so non-power-of-2 NCH works.
    logic              hit;
    logic [CW-1:0]     winner;
    logic              pickWe;
    logic [BW-1:0]     pickBe;
    logic [ADDR_W-1:0] pickAddr;
    logic [DATA_W-1:0] pickWData;

    always_comb begin : pickBlk
        int j;
        j         = 0;
        hit       = 1'b0;
        winner    = '0;
        pickWe    = 1'b0;
        pickBe    = '0;
        pickAddr  = '0;
        pickWData = '0;
        for (int k = 0; k < NCH; k++) begin
            j = int'(rrPtr) + k;
            if (j >= NCH) begin
                j = j - NCH;
            end
            if (!hit && iReq[j]) begin
                hit       = 1'b1;
                winner    = CW'(j);
                pickWe    = iWe[j];
                pickBe    = iBE[j*BW +: BW];
                pickAddr  = iAddr[j*ADDR_W +: ADDR_W];
                pickWData = iWData[j*DATA_W +: DATA_W];
            end
        end
    end

    // Next-state and next-output logic; everything lands in registers.
    always_comb begin
        nxtState    = state;
        nxtRrPtr    = rrPtr;
        nxtCh       = curCh;
        nxtWe       = curWe;
        nxtCnt      = cnt;
        nxtGnt      = '0;
        nxtValid    = '0;
        nxtRData    = oRData;
        nxtMemRE    = 1'b0;
        nxtMemWE    = 1'b0;
        nxtMemBE    = oMemBE;
        nxtMemAddr  = oMemAddr;
        nxtMemWData = oMemWData;
        unique case (state)
            sIdle: begin
                if (hit) begin
                    nxtCh          = winner;
                    nxtWe          = pickWe;
                    nxtGnt[winner] = 1'b1;
                    nxtMemRE       = ~pickWe;
                    nxtMemWE       = pickWe;
                    nxtMemBE       = pickBe;
                    nxtMemAddr     = pickAddr;
                    nxtMemWData    = pickWData;
                    nxtState       = sStrobe;
                end
            end
            sStrobe: begin
                nxtCnt   = 3'(LAT - 1);
                nxtState = sWait;
            end
            sWait: begin
                if (cnt == 3'd0) begin
                    if (!curWe) begin
                        nxtRData = iMemRData;
                    end
                    nxtValid[curCh] = 1'b1;
                    nxtState        = sResp;
                end else begin
                    nxtCnt = cnt - 3'd1;
                end
            end
            sResp: begin
                if (curCh == CW'(NCH - 1)) begin
                    nxtRrPtr = '0;
                end else begin
                    nxtRrPtr = curCh + CW'(1);
                end
                nxtState = sIdle;
            end
            default: begin
                nxtState = sIdle;
            end
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (!iRST) begin
            state     <= sIdle;
            rrPtr     <= '0;
            curCh     <= '0;
            curWe     <= 1'b0;
            cnt       <= '0;
            oGnt      <= '0;
            oValid    <= '0;
            oRData    <= '0;
            oMemRE    <= 1'b0;
            oMemWE    <= 1'b0;
            oMemBE    <= '0;
            oMemAddr  <= '0;
            oMemWData <= '0;
        end else begin
            state     <= nxtState;
            rrPtr     <= nxtRrPtr;
            curCh     <= nxtCh;
            curWe     <= nxtWe;
            cnt       <= nxtCnt;
            oGnt      <= nxtGnt;
            oValid    <= nxtValid;
            oRData    <= nxtRData;
            oMemRE    <= nxtMemRE;
            oMemWE    <= nxtMemWE;
            oMemBE    <= nxtMemBE;
            oMemAddr  <= nxtMemAddr;
            oMemWData <= nxtMemWData;
        end
    end

endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// Directed bench for cpu_bus_arbiter: NCH=2/LAT=1 and NCH=3/LAT=3 instances.
// Inputs driven and outputs sampled on the falling edge.
module tb_cpu_bus_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errCnt = 0;
    int chkCnt = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        chkCnt++;
        if (got !== exp) begin
            errCnt++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Instance A: NCH=2, LAT=1
    logic        aRst;
    logic [1:0]  aReq, aWe, aGnt, aValid;
    logic [7:0]  aBE;
    logic [63:0] aAddr, aWData;
    logic [31:0] aRData, aMemAddr, aMemWData, aMemRData;
    logic        aMemRE, aMemWE;
    logic [3:0]  aMemBE;

    cpu_bus_arbiter #(.NCH(2), .ADDR_W(32), .DATA_W(32), .LAT(1)) dutA (
        .iCLK(clk), .iRST(aRst), .iReq(aReq), .iWe(aWe), .iBE(aBE),
        .iAddr(aAddr), .iWData(aWData), .oGnt(aGnt), .oValid(aValid),
        .oRData(aRData), .oMemRE(aMemRE), .oMemWE(aMemWE),
        .oMemBE(aMemBE), .oMemAddr(aMemAddr), .oMemWData(aMemWData),
        .iMemRData(aMemRData)
    );

    // Instance B: NCH=3, LAT=3
    logic        bRst;
    logic [2:0]  bReq, bWe, bGnt, bValid;
    logic [11:0] bBE;
    logic [95:0] bAddr, bWData;
    logic [31:0] bRData, bMemAddr, bMemWData, bMemRData;
    logic        bMemRE, bMemWE;
    logic [3:0]  bMemBE;

    cpu_bus_arbiter #(.NCH(3), .ADDR_W(32), .DATA_W(32), .LAT(3)) dutB (
        .iCLK(clk), .iRST(bRst), .iReq(bReq), .iWe(bWe), .iBE(bBE),
        .iAddr(bAddr), .iWData(bWData), .oGnt(bGnt), .oValid(bValid),
        .oRData(bRData), .oMemRE(bMemRE), .oMemWE(bMemWE),
        .oMemBE(bMemBE), .oMemAddr(bMemAddr), .oMemWData(bMemWData),
        .iMemRData(bMemRData)
    );

    logic [1:0] order [4];
    int nG, v0, v1;

    initial begin
        aRst = 1'b0; aReq = 2'b11; aWe = '0; aBE = 8'hFF;
        aAddr = '0; aWData = '0; aMemRData = '0;
        bRst = 1'b0; bReq = '0; bWe = '0; bBE = 12'hFFF;
        bAddr = '0; bWData = '0; bMemRData = '0;
        nG = 0; v0 = 0; v1 = 0;
        repeat (2) @(negedge clk);

        // T1: reset holds everything at zero
        chk("t1_gnt", 64'(aGnt), 64'h0);
        chk("t1_valid", 64'(aValid), 64'h0);
        chk("t1_re", 64'(aMemRE), 64'h0);
        chk("t1_we", 64'(aMemWE), 64'h0);
        chk("t1_rdata", 64'(aRData), 64'h0);
        chk("t1_addr", 64'(aMemAddr), 64'h0);
        aRst = 1'b1;
        bRst = 1'b1;

        // T3: both channels hold requests for 4 transactions
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (aGnt != 2'b00) begin
                if (nG < 4) order[nG] = aGnt;
                nG++;
            end
            if (aValid[0]) v0++;
            if (aValid[1]) v1++;
        end
        aReq = 2'b00;
        chk("t3_ngnt", 64'(nG), 64'd4);
        chk("t1_first_gnt", 64'(order[0]), 64'h1);
        chk("t3_gnt1", 64'(order[1]), 64'h2);
        chk("t3_gnt2", 64'(order[2]), 64'h1);
        chk("t3_gnt3", 64'(order[3]), 64'h2);
        chk("t3_v0", 64'(v0), 64'd2);
        chk("t3_v1", 64'(v1), 64'd2);

        // T2: single read on ch1
        aReq = 2'b10;
        aWe = 2'b00;
        aAddr[63:32] = 32'h0000_0040;
        aMemRData = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("t2_gnt", 64'(aGnt), 64'h2);
        chk("t2_re", 64'(aMemRE), 64'h1);
        chk("t2_we", 64'(aMemWE), 64'h0);
        chk("t2_addr", 64'(aMemAddr), 64'h40);
        @(negedge clk);
        chk("t2_re_off", 64'(aMemRE), 64'h0);
        chk("t2_valid_early", 64'(aValid), 64'h0);
        @(negedge clk);
        chk("t2_valid", 64'(aValid), 64'h2);
        chk("t2_rdata", 64'(aRData), 64'hDEAD_BEEF);
        aReq = 2'b00;
        @(negedge clk);
        chk("t2_valid_off", 64'(aValid), 64'h0);

        // T4: write on ch0
        aReq = 2'b01;
        aWe = 2'b01;
        aBE[3:0] = 4'b0011;
        aAddr[31:0] = 32'h0000_0100;
        aWData[31:0] = 32'h1234_5678;
        aMemRData = 32'hCAFE_F00D;
        @(negedge clk);
        chk("t4_gnt", 64'(aGnt), 64'h1);
        chk("t4_we", 64'(aMemWE), 64'h1);
        chk("t4_re", 64'(aMemRE), 64'h0);
        chk("t4_be", 64'(aMemBE), 64'h3);
        chk("t4_addr", 64'(aMemAddr), 64'h100);
        chk("t4_wdata", 64'(aMemWData), 64'h1234_5678);
        @(negedge clk);
        chk("t4_we_off", 64'(aMemWE), 64'h0);
        chk("t4_addr_hold", 64'(aMemAddr), 64'h100);
        @(negedge clk);
        chk("t4_valid", 64'(aValid), 64'h1);
        chk("t4_rdata_kept", 64'(aRData), 64'hDEAD_BEEF);
        aReq = 2'b00;
        aWe = 2'b00;

        // T5: LAT=3 read on ch2, data valid only in the capture cycle
        bReq = 3'b100;
        bAddr[95:64] = 32'h0000_0200;
        bMemRData = 32'h0BAD_0BAD;
        @(negedge clk);
        chk("t5_gnt2", 64'(bGnt), 64'h4);
        chk("t5_re", 64'(bMemRE), 64'h1);
        chk("t5_addr", 64'(bMemAddr), 64'h200);
        @(negedge clk);
        chk("t5_gnt_off", 64'(bGnt), 64'h0);
        repeat (2) @(negedge clk);
        chk("t5_valid_early", 64'(bValid), 64'h0);
        bMemRData = 32'h1111_2222;
        @(negedge clk);
        chk("t5_valid2", 64'(bValid), 64'h4);
        chk("t5_rdata2", 64'(bRData), 64'h1111_2222);
        bMemRData = 32'h0BAD_0BAD;
        // rr wrapped to 0, so ch0 beats ch1
        bReq = 3'b011;
        bAddr[31:0] = 32'h0000_0300;
        bAddr[63:32] = 32'h0000_0400;
        @(negedge clk);
        chk("t5_idle_gnt", 64'(bGnt), 64'h0);
        @(negedge clk);
        chk("t5_wrap_gnt", 64'(bGnt), 64'h1);
        chk("t5_addr0", 64'(bMemAddr), 64'h300);
        repeat (3) @(negedge clk);
        bMemRData = 32'h3333_4444;
        @(negedge clk);
        chk("t5_valid0", 64'(bValid), 64'h1);
        chk("t5_rdata0", 64'(bRData), 64'h3333_4444);
        bMemRData = 32'h0BAD_0BAD;
        bReq = 3'b010;

        // T6: reset during WAIT of the ch1 read
        @(negedge clk);
        @(negedge clk);
        chk("t6_gnt1", 64'(bGnt), 64'h2);
        @(negedge clk);
        bRst = 1'b0;
        @(negedge clk);
        chk("t6_valid", 64'(bValid), 64'h0);
        chk("t6_gnt", 64'(bGnt), 64'h0);
        chk("t6_rdata", 64'(bRData), 64'h0);
        chk("t6_addr", 64'(bMemAddr), 64'h0);
        chk("t6_re", 64'(bMemRE), 64'h0);
        bRst = 1'b1;
        bReq = 3'b011;
        @(negedge clk);
        chk("t6_rr_reset", 64'(bGnt), 64'h1);
        chk("t6_no_valid", 64'(bValid), 64'h0);
        bReq = 3'b000;
        repeat (6) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
        $finish;
    end

endmodule
